// File: rtl/rx_packet_arbiter.sv
// Round-robin arbiter that merges NUM_SRC packet sources into one source-tagged FIFO.
// The host pops one entry per read_req, and the popped entry appears on packet_in one cycle later.
module rx_packet_arbiter #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned PACKET_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned SRC_W        = $clog2(NUM_SRC),
  parameter int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC*PACKET_WIDTH-1:0]   src_packet,
  input  logic [NUM_SRC-1:0]                src_valid,
  output logic [NUM_SRC-1:0]                src_ack,
  input  logic                              read_req,
  output logic [PACKET_WIDTH-1:0]           packet_in,
  output logic [SRC_W-1:0]                  packet_in_src,
  output logic                              packet_in_valid,
  output logic                              fifo_empty,
  output logic                              fifo_full,
  output logic [CNT_W-1:0]                  fifo_count,
  output logic                              underflow_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [SRC_W-1:0]        src;
    logic [PACKET_WIDTH-1:0] data;
  } entry_t;

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] scan_idx;
  logic             grant_found;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             pop;
  logic             push;
  logic             can_accept;
  entry_t           wr_entry;
  entry_t           mem [FIFO_DEPTH];

  assign pop        = read_req && (count != '0);
  assign can_accept = (count < CNT_W'(FIFO_DEPTH)) || pop;
  assign push       = rst && can_accept && grant_found;
  assign fifo_count = count;

  // First valid source at or after rr_ptr, wrapping modulo NUM_SRC
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      scan_idx = rr_ptr + SRC_W'(k);
      if (!grant_found && src_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    src_ack = '0;
    if (push) begin
      src_ack[grant_idx] = 1'b1;
    end
  end

  // Select the granted packet with constant slices and tag it with its source
  always_comb begin
    wr_entry      = '0;
    wr_entry.src  = grant_idx;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        wr_entry.data = src_packet[i*PACKET_WIDTH +: PACKET_WIDTH];
      end
    end
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage array has no reset; occupancy is tracked by count and the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr          <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      fifo_empty      <= 1'b1;
      fifo_full       <= 1'b0;
      packet_in       <= '0;
      packet_in_src   <= '0;
      packet_in_valid <= 1'b0;
      underflow_err   <= 1'b0;
    end else begin
      count           <= count_nxt;
      fifo_empty      <= (count_nxt == '0);
      fifo_full       <= (count_nxt == CNT_W'(FIFO_DEPTH));
      packet_in_valid <= pop;
      if (push) begin
        rr_ptr <= grant_idx + SRC_W'(1);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        packet_in     <= mem[rd_ptr].data;
        packet_in_src <= mem[rd_ptr].src;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      if (read_req && (count == '0)) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_packet_arbiter.sv
// Scoreboard bench for rx_packet_arbiter: a reference model predicts acks and occupancy,
// and every accepted packet is queued and compared when the host-side pulse appears.
module tb_rx_packet_arbiter;

  localparam int unsigned NS    = 4;
  localparam int unsigned PW    = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS*PW-1:0] src_packet;
  logic [NS-1:0] src_valid;
  logic [NS-1:0] src_ack;
  logic          read_req;
  logic [PW-1:0] packet_in;
  logic [1:0]    packet_in_src;
  logic          packet_in_valid;
  logic          fifo_empty;
  logic          fifo_full;
  logic [3:0]    fifo_count;
  logic          underflow_err;

  rx_packet_arbiter #(.NUM_SRC(NS), .PACKET_WIDTH(PW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .src_packet(src_packet), .src_valid(src_valid),
    .src_ack(src_ack), .read_req(read_req), .packet_in(packet_in),
    .packet_in_src(packet_in_src), .packet_in_valid(packet_in_valid),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state and scoreboard of {src, packet}
  logic [33:0] sb [$];
  int          m_count;
  logic [1:0]  m_rr;
  bit          m_uf;

  logic [3:0]  exp_ack, obs_ack;
  bit          exp_valid;
  logic        obs_valid, obs_empty, obs_full, obs_uf;
  logic [31:0] obs_pkt;
  logic [1:0]  obs_src;
  logic [3:0]  obs_count;
  logic [33:0] e;

  // Drive one cycle from just after a falling edge, advance the model, sample after the rising edge
  task automatic tick(input logic [3:0] v, input logic rd);
    bit pop, can, found;
    logic [1:0] idx;
    src_valid = v;
    read_req  = rd;
    #1;
    obs_ack = src_ack;
    pop   = rd && (m_count != 0);
    can   = (m_count < DEPTH) || pop;
    found = 1'b0;
    exp_ack = '0;
    if (can) begin
      for (int k = 0; k < 4; k++) begin
        idx = m_rr + 2'(k);
        if (!found && v[idx]) begin
          found = 1'b1;
          exp_ack[idx] = 1'b1;
          sb.push_back({idx, src_packet[int'(idx)*32 +: 32]});
          m_rr = idx + 2'd1;
        end
      end
    end
    if (rd && m_count == 0) m_uf = 1'b1;
    exp_valid = pop;
    m_count = m_count + (found ? 1 : 0) - (pop ? 1 : 0);
    @(posedge clk);
    #1;
    obs_valid = packet_in_valid;
    obs_pkt   = packet_in;
    obs_src   = packet_in_src;
    obs_count = fifo_count;
    obs_empty = fifo_empty;
    obs_full  = fifo_full;
    obs_uf    = underflow_err;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    src_valid = '0;
    read_req  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    m_count = 0;
    m_rr = '0;
    m_uf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    src_valid = 4'hF;
    read_req  = 1'b1;
    src_packet = '0;
    #1;
    n_checks++; if (src_ack !== 4'h0) $display("FAIL reset_ack got=%h want=0", src_ack); else n_pass++;
    @(negedge clk);
    n_checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_count !== 4'd0)
      $display("FAIL reset_flags got e=%b f=%b c=%0d want e=1 f=0 c=0", fifo_empty, fifo_full, fifo_count);
    else n_pass++;
    n_checks++; if (packet_in_valid !== 1'b0 || underflow_err !== 1'b0 || packet_in !== 32'h0 || packet_in_src !== 2'd0)
      $display("FAIL reset_out got v=%b uf=%b p=%h s=%0d want all 0", packet_in_valid, underflow_err, packet_in, packet_in_src);
    else n_pass++;
    apply_reset();
    tick(4'h0, 1'b0);
    n_checks++; if (obs_ack !== 4'h0 || obs_valid !== 1'b0 || obs_count !== 4'd0 || obs_empty !== 1'b1)
      $display("FAIL idle got ack=%h v=%b c=%0d e=%b want ack=0 v=0 c=0 e=1", obs_ack, obs_valid, obs_count, obs_empty);
    else n_pass++;
  endtask

  task automatic test_single();
    src_packet[2*32 +: 32] = 32'hDEAD_BEEF;
    tick(4'b0100, 1'b0);
    n_checks++; if (obs_ack !== exp_ack || obs_ack !== 4'b0100) $display("FAIL single_ack got=%b want=0100", obs_ack); else n_pass++;
    n_checks++; if (obs_count !== 4'd1 || obs_empty !== 1'b0) $display("FAIL single_count got=%0d want=1", obs_count); else n_pass++;
    tick(4'b0000, 1'b1);
    n_checks++; if (obs_valid !== exp_valid || obs_valid !== 1'b1) $display("FAIL single_valid got=%b want=1", obs_valid); else n_pass++;
    if (obs_valid) begin
      n_checks++;
      if (sb.size() == 0) $display("FAIL single_sb got=unexpected-output want=none");
      else begin
        e = sb.pop_front();
        if ({obs_src, obs_pkt} !== e || obs_pkt !== 32'hDEAD_BEEF || obs_src !== 2'd2)
          $display("FAIL single_data got=%0d:%h want=%0d:%h", obs_src, obs_pkt, e[33:32], e[31:0]);
        else n_pass++;
      end
    end
    tick(4'b0000, 1'b0);
    n_checks++; if (obs_valid !== 1'b0 || obs_pkt !== 32'hDEAD_BEEF) $display("FAIL single_pulse got v=%b p=%h want v=0 p=deadbeef", obs_valid, obs_pkt); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_src [8];
    exp_src = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    apply_reset();
    for (int j = 0; j < 4; j++) src_packet[j*32 +: 32] = 32'h10 + 32'(j);
    for (int k = 0; k < 8; k++) begin
      tick(4'hF, 1'b0);
      n_checks++; if (obs_ack !== exp_ack || obs_ack !== 4'(1 << (k % 4)))
        $display("FAIL rr_ack[%0d] got=%b want=%b", k, obs_ack, 4'(1 << (k % 4)));
      else n_pass++;
    end
    for (int k = 0; k < 2; k++) begin
      tick(4'hF, 1'b0);
      n_checks++; if (obs_ack !== 4'h0 || obs_full !== 1'b1 || obs_count !== 4'd8)
        $display("FAIL rr_full got ack=%b f=%b c=%0d want ack=0 f=1 c=8", obs_ack, obs_full, obs_count);
      else n_pass++;
    end
    // Full queue: push from source 1 and pop in the same cycle
    src_packet[1*32 +: 32] = 32'h21;
    tick(4'b0010, 1'b1);
    n_checks++; if (obs_ack !== exp_ack || obs_ack !== 4'b0010) $display("FAIL fullpop_ack got=%b want=0010", obs_ack); else n_pass++;
    n_checks++; if (obs_count !== 4'd8 || obs_full !== 1'b1) $display("FAIL fullpop_count got=%0d want=8", obs_count); else n_pass++;
    n_checks++;
    if (obs_valid !== 1'b1 || sb.size() == 0) $display("FAIL fullpop_valid got=%b want=1", obs_valid);
    else begin
      e = sb.pop_front();
      if ({obs_src, obs_pkt} !== e || obs_pkt !== 32'h10) $display("FAIL fullpop_data got=%0d:%h want=0:10", obs_src, obs_pkt);
      else n_pass++;
    end
    for (int k = 0; k < 8; k++) begin
      tick(4'h0, 1'b1);
      n_checks++;
      if (obs_valid !== 1'b1 || sb.size() == 0) $display("FAIL drain_valid[%0d] got=%b want=1", k, obs_valid);
      else begin
        e = sb.pop_front();
        if ({obs_src, obs_pkt} !== e || obs_src !== exp_src[k])
          $display("FAIL drain_data[%0d] got=%0d:%h want=%0d:%h", k, obs_src, obs_pkt, exp_src[k], e[31:0]);
        else n_pass++;
      end
    end
    n_checks++; if (obs_count !== 4'd0 || obs_empty !== 1'b1 || obs_pkt !== 32'h21)
      $display("FAIL drain_end got c=%0d e=%b p=%h want c=0 e=1 p=21", obs_count, obs_empty, obs_pkt);
    else n_pass++;
  endtask

  task automatic test_underflow_and_mid_reset();
    tick(4'h0, 1'b1);
    n_checks++; if (obs_valid !== 1'b0 || obs_uf !== 1'b1 || obs_uf !== m_uf)
      $display("FAIL underflow got v=%b uf=%b want v=0 uf=1", obs_valid, obs_uf);
    else n_pass++;
    src_packet[3*32 +: 32] = 32'hCAFE_0003;
    tick(4'b1000, 1'b0);
    tick(4'b0000, 1'b1);
    n_checks++; if (obs_uf !== 1'b1 || obs_valid !== 1'b1 || obs_pkt !== 32'hCAFE_0003)
      $display("FAIL underflow_sticky got uf=%b v=%b p=%h want uf=1 v=1 p=cafe0003", obs_uf, obs_valid, obs_pkt);
    else n_pass++;
    if (sb.size() != 0) void'(sb.pop_front());
    // Fill to five entries, then assert reset between clock edges
    for (int k = 0; k < 5; k++) tick(4'hF, 1'b0);
    n_checks++; if (obs_count !== 4'd5) $display("FAIL mid_fill got=%0d want=5", obs_count); else n_pass++;
    src_valid = 4'hF;
    rst = 1'b0;
    #1;
    n_checks++; if (fifo_count !== 4'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 || src_ack !== 4'h0)
      $display("FAIL mid_reset got c=%0d e=%b f=%b ack=%b want c=0 e=1 f=0 ack=0", fifo_count, fifo_empty, fifo_full, src_ack);
    else n_pass++;
    n_checks++; if (underflow_err !== 1'b0 || packet_in !== 32'h0 || packet_in_valid !== 1'b0)
      $display("FAIL mid_reset_out got uf=%b p=%h v=%b want 0", underflow_err, packet_in, packet_in_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++; if (src_ack !== 4'h0 || fifo_count !== 4'd0) $display("FAIL held_reset got ack=%b c=%0d want 0", src_ack, fifo_count); else n_pass++;
    @(negedge clk);
    apply_reset();
  endtask

  task automatic test_wrap();
    int s, pushes, pops, guard;
    logic rd;
    pushes = 0;
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      s = i % 4;
      src_packet[s*32 +: 32] = $urandom;
      rd = (m_count >= 3) || (m_count >= 1 && (i % 3) == 2);
      tick(4'(1 << s), rd);
      pushes++;
      n_checks++; if (obs_ack !== exp_ack || obs_count !== 4'(m_count))
        $display("FAIL wrap_ack[%0d] got ack=%b c=%0d want ack=%b c=%0d", i, obs_ack, obs_count, exp_ack, m_count);
      else n_pass++;
      n_checks++; if (obs_valid !== exp_valid) $display("FAIL wrap_valid[%0d] got=%b want=%b", i, obs_valid, exp_valid); else n_pass++;
      if (obs_valid) begin
        pops++;
        n_checks++;
        if (sb.size() == 0) $display("FAIL wrap_sb[%0d] got=unexpected-output want=none", i);
        else begin
          e = sb.pop_front();
          if ({obs_src, obs_pkt} !== e) $display("FAIL wrap_data[%0d] got=%0d:%h want=%0d:%h", i, obs_src, obs_pkt, e[33:32], e[31:0]);
          else n_pass++;
        end
      end
    end
    guard = 0;
    while (m_count > 0 && guard < 16) begin
      tick(4'h0, 1'b1);
      guard++;
      n_checks++;
      if (obs_valid !== 1'b1 || sb.size() == 0) $display("FAIL wrap_drain_valid got=%b want=1", obs_valid);
      else begin
        pops++;
        e = sb.pop_front();
        if ({obs_src, obs_pkt} !== e) $display("FAIL wrap_drain_data got=%0d:%h want=%0d:%h", obs_src, obs_pkt, e[33:32], e[31:0]);
        else n_pass++;
      end
    end
    n_checks++; if (pops !== pushes || obs_empty !== 1'b1 || sb.size() != 0)
      $display("FAIL wrap_total got pops=%0d e=%b want pops=%0d e=1", pops, obs_empty, pushes);
    else n_pass++;
  endtask

  initial begin
    sb.delete();
    m_count = 0;
    m_rr = '0;
    m_uf = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_underflow_and_mid_reset();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_packet_arbiter.md
Name: rx_packet_arbiter

Overview:
- Shares one host-side receive path between NUM_SRC packet sources (core output ports).
- Round-robin arbitration with valid/ack handshakes.
- Accepted packets are queued in a FIFO tagged with source index.
- The host drains one entry per read_req; output has registered one-cycle latency.

Parameters:
- NUM_SRC, 4, number of requesting sources; power of two, minimum 2.
- PACKET_WIDTH, 32, bits per packet.
- FIFO_DEPTH, 8, queue entries; power of two, minimum 2.
- SRC_W, $clog2(NUM_SRC), derived, width of the source tag.
- CNT_W, $clog2(FIFO_DEPTH)+1, derived, width of the occupancy count.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- src_packet  input  NUM_SRC*PACKET_WIDTH  packet from source i at bits [i*PACKET_WIDTH +: PACKET_WIDTH].
- src_valid  input  NUM_SRC  source i has a packet pending.
- src_ack  output  NUM_SRC  one-hot, combinational; packet of source i captured at this clock edge.
- read_req  input  1  host pop request.
- packet_in  output  PACKET_WIDTH  popped packet.
- packet_in_src  output  SRC_W  source index of popped packet.
- packet_in_valid  output  1  one-cycle pulse; packet_in and packet_in_src are valid.
- fifo_empty  output  1  queue holds 0 entries.
- fifo_full  output  1  queue holds FIFO_DEPTH entries.
- fifo_count  output  CNT_W  current occupancy.
- underflow_err  output  1  sticky flag, set by read_req while empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - rr_ptr=0, wr_ptr=0, rd_ptr=0, count=0.
  - packet_in=0, packet_in_src=0, packet_in_valid=0, underflow_err=0.
  - Therefore fifo_empty=1, fifo_full=0, src_ack=0.
  - Assertion mid-operation discards all queued entries immediately; no ack is issued while rst=0.
- Source handshake:
  - A source raises src_valid[i] and holds src_valid and its packet stable until the cycle in which src_ack[i]=1.
  - It may drop valid or change the packet the cycle after the ack.
  - Packet transfer occurs at the rising edge in the cycle where src_ack[i]=1.
- Arbitration:
  - can_accept = (count < FIFO_DEPTH) OR (pop this cycle).
  - When can_accept, grant the first i with src_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - At most one grant per cycle; src_ack is the one-hot grant, all zero when no grant.
  - On a grant to i, rr_ptr <= (i+1) mod NUM_SRC; rr_ptr is unchanged when there is no grant.
  - With all sources continuously valid, grants rotate 0,1,2,3,0,... with no source starved.
  - When can_accept=0, no ack is issued and rr_ptr holds.
- FIFO:
  - Write stores {i, packet} at wr_ptr; wr_ptr increments and wraps modulo FIFO_DEPTH.
  - pop = read_req AND (count != 0).
  - Pop reads the entry at rd_ptr into the packet_in and packet_in_src registers and sets packet_in_valid=1 on the next cycle (latency 1). rd_ptr then wraps.
  - packet_in_valid=0 in every other cycle; packet_in and packet_in_src hold their last value.
  - Count: push only +1; pop only -1; push and pop together leaves count unchanged.
  - Simultaneous push and pop on a full queue is legal: count stays FIFO_DEPTH and the freed slot is reused.
  - Simultaneous push and pop on an empty queue is not possible: a pop needs count != 0, so the new entry is not bypassed.
  - fifo_empty, fifo_full and fifo_count are registered, derived from count; they reflect the state after the last edge.
- Errors:
  - read_req with count=0: no pop and no valid pulse; underflow_err <= 1 and stays set until reset.
  - No overflow is possible: a full queue without a pop withholds ack.
- Ordering: FIFO order equals grant order; per-source order is preserved.

Test Plan:
- Reset, then idle: fifo_empty=1, fifo_count=0, src_ack=0, packet_in_valid=0. Assert rst=0 mid-burst with count=5: outputs return to reset values on the same edge.
- Single source: src_valid=4'b0100, packet 0xDEAD_BEEF, one-cycle ack on bit 2. Then read_req for one cycle: the next cycle has packet_in=0xDEADBEEF, packet_in_src=2 and a one-cycle packet_in_valid pulse.
- Round-robin: all four sources held valid with distinct packets 0x10..0x13, read_req=0. Ack sequence is 0,1,2,3,0,1,2,3 over 8 cycles. fifo_full=1 afterwards and src_ack=0 thereafter. Drain yields sources 0,1,2,3,0,1,2,3 in order.
- Full with simultaneous pop: queue at 8, src_valid[1]=1, read_req=1. Same cycle: ack on bit 1 and a pop; fifo_count stays 8 and the new entry is read last.
- Underflow: read_req=1 while empty. No packet_in_valid pulse; underflow_err=1 persists through later valid traffic until rst=0.
- Pointer wrap: 20 single-source pushes interleaved with pops at count 1..3. Packets are popped in exact push order across the wr_ptr and rd_ptr wrap.
